// File: rtl/cdb_arbiter_if.sv
// Result-side bus bundle for cdb_arbiter: adder/multiplier result inputs, CDB broadcast and
// FIFO occupancy. The slave modport is the arbiter's view, the master modport is its environment.
interface cdb_arbiter_if #(
    parameter int unsigned TAG_W      = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 2
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic              add_in_valid;
    logic [TAG_W-1:0]  add_in_tag;
    logic [DATA_W-1:0] add_in_data;
    logic              add_in_ready;
    logic              mul_in_valid;
    logic [TAG_W-1:0]  mul_in_tag;
    logic [DATA_W-1:0] mul_in_data;
    logic              mul_in_ready;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              cdb_src;
    logic [CntW-1:0]   add_count;
    logic [CntW-1:0]   mul_count;

    modport slave (
        input  add_in_valid, add_in_tag, add_in_data,
        input  mul_in_valid, mul_in_tag, mul_in_data,
        output add_in_ready, mul_in_ready,
        output cdb_valid, cdb_tag, cdb_data, cdb_src,
        output add_count, mul_count
    );

    modport master (
        output add_in_valid, add_in_tag, add_in_data,
        output mul_in_valid, mul_in_tag, mul_in_data,
        input  add_in_ready, mul_in_ready,
        input  cdb_valid, cdb_tag, cdb_data, cdb_src,
        input  add_count, mul_count
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: two private result FIFOs (adder, multiplier), one registered broadcast
// per cycle, round-robin on contention. Define CDB_MUL_PRIORITY_EN to give the multiplier priority.
module cdb_arbiter #(
    parameter int unsigned TAG_W      = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    cdb_arbiter_if.slave bus
);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned EntW  = TAG_W + DATA_W;
    localparam logic [CntW-1:0] Full = CntW'(FIFO_DEPTH);

    localparam logic SrcAdd = 1'b0;
    localparam logic SrcMul = 1'b1;

    logic [EntW-1:0]   add_mem_q [FIFO_DEPTH];
    logic [EntW-1:0]   mul_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   add_wr_q, add_wr_d, add_rd_q, add_rd_d;
    logic [PtrW-1:0]   mul_wr_q, mul_wr_d, mul_rd_q, mul_rd_d;
    logic [CntW-1:0]   add_cnt_q, add_cnt_d, mul_cnt_q, mul_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic              cdb_src_q, cdb_src_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;

    logic add_ready, mul_ready, add_push, mul_push, add_pop, mul_pop;
    logic add_ne, mul_ne, gnt_valid, gnt_src;
    logic [EntW-1:0] add_head, mul_head, gnt_ent;

    // Ready comes from the registered count only, so a full FIFO stays not-ready while popping.
    assign add_ready = (add_cnt_q != Full);
    assign mul_ready = (mul_cnt_q != Full);
    assign add_push  = bus.add_in_valid && add_ready;
    assign mul_push  = bus.mul_in_valid && mul_ready;
    assign add_ne    = (add_cnt_q != '0);
    assign mul_ne    = (mul_cnt_q != '0);
    assign add_head  = add_mem_q[add_rd_q];
    assign mul_head  = mul_mem_q[mul_rd_q];

    always_comb begin
        gnt_valid = add_ne || mul_ne;
        gnt_src   = SrcAdd;
        if (add_ne && mul_ne) begin
`ifdef CDB_MUL_PRIORITY_EN
            gnt_src = SrcMul;
`else
            gnt_src = ~last_grant_q;
`endif
        end else if (mul_ne) begin
            gnt_src = SrcMul;
        end
    end

    assign add_pop = gnt_valid && (gnt_src == SrcAdd);
    assign mul_pop = gnt_valid && (gnt_src == SrcMul);
    assign gnt_ent = (gnt_src == SrcMul) ? mul_head : add_head;

    always_comb begin
        add_wr_d     = add_push ? add_wr_q + PtrW'(1) : add_wr_q;
        mul_wr_d     = mul_push ? mul_wr_q + PtrW'(1) : mul_wr_q;
        add_rd_d     = add_pop ? add_rd_q + PtrW'(1) : add_rd_q;
        mul_rd_d     = mul_pop ? mul_rd_q + PtrW'(1) : mul_rd_q;
        add_cnt_d    = add_cnt_q + CntW'(add_push) - CntW'(add_pop);
        mul_cnt_d    = mul_cnt_q + CntW'(mul_push) - CntW'(mul_pop);
        last_grant_d = gnt_valid ? gnt_src : last_grant_q;
        cdb_valid_d  = gnt_valid;
        cdb_src_d    = cdb_src_q;
        cdb_tag_d    = cdb_tag_q;
        cdb_data_d   = cdb_data_q;
        if (gnt_valid) begin
            cdb_src_d  = gnt_src;
            cdb_tag_d  = gnt_ent[EntW-1:DATA_W];
            cdb_data_d = gnt_ent[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && add_push) add_mem_q[add_wr_q] <= {bus.add_in_tag, bus.add_in_data};
        if (!rst && mul_push) mul_mem_q[mul_wr_q] <= {bus.mul_in_tag, bus.mul_in_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            add_wr_q     <= '0;
            add_rd_q     <= '0;
            add_cnt_q    <= '0;
            mul_wr_q     <= '0;
            mul_rd_q     <= '0;
            mul_cnt_q    <= '0;
            last_grant_q <= SrcMul;
            cdb_valid_q  <= 1'b0;
            cdb_src_q    <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_data_q   <= '0;
        end else begin
            add_wr_q     <= add_wr_d;
            add_rd_q     <= add_rd_d;
            add_cnt_q    <= add_cnt_d;
            mul_wr_q     <= mul_wr_d;
            mul_rd_q     <= mul_rd_d;
            mul_cnt_q    <= mul_cnt_d;
            last_grant_q <= last_grant_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_src_q    <= cdb_src_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_data_q   <= cdb_data_d;
        end
    end

    assign bus.add_in_ready = add_ready;
    assign bus.mul_in_ready = mul_ready;
    assign bus.add_count    = add_cnt_q;
    assign bus.mul_count    = mul_cnt_q;
    assign bus.cdb_valid    = cdb_valid_q;
    assign bus.cdb_src      = cdb_src_q;
    assign bus.cdb_tag      = cdb_tag_q;
    assign bus.cdb_data     = cdb_data_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed and random result pushes checked every cycle against a
// queue-based model of the two holding FIFOs and the CDB grant rule.
module tb_cdb_arbiter;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    cdb_arbiter_if #(.TAG_W(TAG_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) bus ();

    cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: each queue entry is {tag, data}; lg is the source granted most recently.
    logic [15:0] aq[$];
    logic [15:0] mq[$];
    bit          lg = 1'b1;
    bit          e_valid = 1'b0;
    bit          e_src = 1'b0;
    logic [7:0]  e_tag = '0;
    logic [7:0]  e_data = '0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", name, obs, exp, $time);
        end
    endtask

    task automatic step(input bit av, input logic [7:0] at, input logic [7:0] ad,
                        input bit mv, input logic [7:0] mt, input logic [7:0] md,
                        input bit r);
        bit acc_a, acc_m, g;
        logic [15:0] e;
        bus.add_in_valid = av;
        bus.add_in_tag   = at;
        bus.add_in_data  = ad;
        bus.mul_in_valid = mv;
        bus.mul_in_tag   = mt;
        bus.mul_in_data  = md;
        rst              = r;
        acc_a = av && (aq.size() < DEPTH);
        acc_m = mv && (mq.size() < DEPTH);
        @(posedge clk);
        if (r) begin
            aq.delete();
            mq.delete();
            lg = 1'b1;
            e_valid = 1'b0;
            e_src = 1'b0;
            e_tag = '0;
            e_data = '0;
        end else begin
            e_valid = (aq.size() != 0) || (mq.size() != 0);
            if (e_valid) begin
                if (aq.size() != 0 && mq.size() != 0) begin
`ifdef CDB_MUL_PRIORITY_EN
                    g = 1'b1;
`else
                    g = !lg;
`endif
                end else begin
                    g = (mq.size() != 0);
                end
                e = g ? mq.pop_front() : aq.pop_front();
                e_src = g;
                e_tag = e[15:8];
                e_data = e[7:0];
                lg = g;
            end
            if (acc_a) aq.push_back({at, ad});
            if (acc_m) mq.push_back({mt, md});
        end
        #1;
        chk("cdb_valid", bus.cdb_valid, e_valid);
        chk("cdb_tag", bus.cdb_tag, e_tag);
        chk("cdb_data", bus.cdb_data, e_data);
        chk("cdb_src", bus.cdb_src, e_src);
        chk("add_count", bus.add_count, aq.size());
        chk("mul_count", bus.mul_count, mq.size());
        chk("add_in_ready", bus.add_in_ready, aq.size() != DEPTH);
        chk("mul_in_ready", bus.mul_in_ready, mq.size() != DEPTH);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, 0);
    endtask

    initial begin
        int mpushed;
        bus.add_in_valid = 1'b0;
        bus.add_in_tag   = '0;
        bus.add_in_data  = '0;
        bus.mul_in_valid = 1'b0;
        bus.mul_in_tag   = '0;
        bus.mul_in_data  = '0;

        // Reset then idle.
        step(0, '0, '0, 0, '0, '0, 1);
        step(0, '0, '0, 0, '0, '0, 1);
        idle(10);

        // Single adder result: broadcast one cycle later, then valid drops.
        step(1, 8'h03, 8'h2A, 0, '0, '0, 0);
        step(0, '0, '0, 0, '0, '0, 0);
        chk("single_tag", bus.cdb_tag, 32'h03);
        chk("single_data", bus.cdb_data, 32'h2A);
        idle(2);

        // Simultaneous adder and multiplier results.
        step(1, 8'h01, 8'h11, 1, 8'h05, 8'h55, 0);
        idle(3);

        // Adder floods while three multiplier results are pushed back-to-back.
        mpushed = 0;
        for (int i = 0; i < 10; i++) begin
            bit mrdy;
            mrdy = (mq.size() < DEPTH) && (mpushed < 3);
            step(1, 8'h20 + 8'(i), 8'(i * 3), mpushed < 3, 8'h10 + 8'(mpushed), 8'hA0 + 8'(mpushed),
                 0);
            if (mrdy) mpushed++;
        end
        chk("mul_all_pushed", mpushed, 3);
        idle(6);

        // Fill both FIFOs, keep pushing into full FIFOs, then reset mid-stream.
        for (int i = 0; i < 5; i++)
            step(1, 8'h40 + 8'(i), 8'h60 + 8'(i), 1, 8'h80 + 8'(i), 8'hC0 + 8'(i), 0);
        step(1, 8'hEE, 8'hEE, 1, 8'hEF, 8'hEF, 1);
        idle(3);
        step(1, 8'h07, 8'h77, 0, '0, '0, 0);
        step(0, '0, '0, 0, '0, '0, 0);
        chk("post_reset_tag", bus.cdb_tag, 32'h07);
        idle(2);

        // Random traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 1), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 1), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 60) == 0);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
